// File: rtl/md_cart_pkg.sv
// md_cart_pkg: shared types and constants for the cartridge responder.
//   cart_state_e : read FSM states
//   PAGE_BITS    : word-offset width of one 512 KB page
//   BANK_W       : bank register width (64 pages of 512 KB)
//   NUM_BANKS    : number of page slots in the 4 MB window
//   TIME_WIN     : cart_address[6:3] value selecting the bank registers
package md_cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ABORT,
    ST_DRIVE
  } cart_state_e;

  localparam int PAGE_BITS = 18;
  localparam int BANK_W    = 6;
  localparam int NUM_BANKS = 8;

  localparam logic [3:0] TIME_WIN = 4'hF;

endpackage

// File: rtl/md_cart_mapper.sv
// md_cart_mapper: SSF2-style page mapper.
//   MCLK         in  : master clock
//   ext_reset    in  : synchronous active-high reset (bank[i] <= i)
//   wr_evt       in  : one-cycle /TIME write event
//   cart_address in  : board word address A1..A23
//   cart_data_in in  : board write data (low 6 bits select the page)
//   map_addr     out : ROM word address, fitted to ROM_AW
module md_cart_mapper
  import md_cart_pkg::*;
#(
  parameter int ROM_AW    = 24,
  parameter int MAPPER_EN = 1
) (
  input  logic              MCLK,
  input  logic              ext_reset,
  input  logic              wr_evt,
  input  logic [22:0]       cart_address,
  input  logic [15:0]       cart_data_in,
  output logic [ROM_AW-1:0] map_addr
);

  logic [BANK_W-1:0] bank [NUM_BANKS];
  logic [2:0]        page_idx;
  logic [31:0]       full_addr;

  assign page_idx = cart_address[PAGE_BITS+2:PAGE_BITS];

  // Slot 0 is hard-wired to page 0 so the vector table never moves.
  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      for (int i = 0; i < NUM_BANKS; i++) bank[i] <= BANK_W'(i);
    end else if (wr_evt && cart_address[6:3] == TIME_WIN &&
                 cart_address[2:0] != 3'd0) begin
      bank[cart_address[2:0]] <= cart_data_in[BANK_W-1:0];
    end
  end

  // Build the address in a wide container, then zero-extend or truncate.
  always_comb begin
    full_addr = '0;
    if (MAPPER_EN != 0)
      full_addr[PAGE_BITS+BANK_W-1:0] = {bank[page_idx], cart_address[PAGE_BITS-1:0]};
    else
      full_addr[22:0] = cart_address;
  end

  assign map_addr = full_addr[ROM_AW-1:0];

endmodule

// File: rtl/md_cart_responder.sv
// md_cart_responder: cart-slot responder serving ROM reads over req/ack.
//   MCLK, ext_reset            : clock, synchronous active-high reset
//   cart_address, cart_data_in : board address / write data
//   cart_ce0_n, cart_oe_n      : ROM select and read strobe (active low)
//   cart_lwr_n, cart_time_n    : low-byte write and /TIME select (active low)
//   cart_data, cart_data_en    : read data and its drive enable
//   M3                         : mode select, tied to MD mode
//   rom_req, rom_addr          : memory request and word address
//   rom_ack, rom_q             : completion pulse and same-cycle read data
//
// state    | meaning
// ST_IDLE  | waiting for ce0 and oe both low
// ST_REQ   | rom_req high, waiting for ack
// ST_ABORT | strobe released early; hold rom_req until ack, drop data
// ST_DRIVE | driving cart_data until ce0 or oe released
module md_cart_responder
  import md_cart_pkg::*;
#(
  parameter int ROM_AW    = 24,
  parameter int MAPPER_EN = 1
) (
  input  logic              MCLK,
  input  logic              ext_reset,
  input  logic [22:0]       cart_address,
  input  logic [15:0]       cart_data_in,
  input  logic              cart_ce0_n,
  input  logic              cart_oe_n,
  input  logic              cart_lwr_n,
  input  logic              cart_time_n,
  output logic [15:0]       cart_data,
  output logic              cart_data_en,
  output logic              M3,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_q
);

  cart_state_e       state, state_nxt;
  logic [3:0]        sync1, sync2;  // {time, lwr, oe, ce0}
  logic              ce0_s, oe_s, lwr_s, time_s;
  logic              sel, wr_act, wr_act_q, wr_evt;
  logic [ROM_AW-1:0] map_addr;

  assign M3 = 1'b0;

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      sync1    <= 4'hF;
      sync2    <= 4'hF;
      wr_act_q <= 1'b0;
    end else begin
      sync1    <= {cart_time_n, cart_lwr_n, cart_oe_n, cart_ce0_n};
      sync2    <= sync1;
      wr_act_q <= wr_act;
    end
  end

  assign {time_s, lwr_s, oe_s, ce0_s} = sync2;
  assign sel    = ~ce0_s & ~oe_s;
  // Register writes only count with ce0 high; ROM-area writes are dropped.
  assign wr_act = ~time_s & ~lwr_s & ce0_s;
  assign wr_evt = wr_act & ~wr_act_q;

  md_cart_mapper #(
    .ROM_AW    (ROM_AW),
    .MAPPER_EN (MAPPER_EN)
  ) u_mapper (
    .MCLK         (MCLK),
    .ext_reset    (ext_reset),
    .wr_evt       (wr_evt),
    .cart_address (cart_address),
    .cart_data_in (cart_data_in),
    .map_addr     (map_addr)
  );

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      cart_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && sel) rom_addr <= map_addr;
      if (state == ST_REQ && rom_ack) cart_data <= rom_q;
    end
  end

  // An ack coinciding with release still completes; DRIVE then exits next cycle.
  always_comb begin
    state_nxt    = state;
    rom_req      = 1'b0;
    cart_data_en = 1'b0;
    case (state)
      ST_IDLE: if (sel) state_nxt = ST_REQ;
      ST_REQ: begin
        rom_req = 1'b1;
        if (rom_ack) state_nxt = ST_DRIVE;
        else if (!sel) state_nxt = ST_ABORT;
      end
      ST_ABORT: begin
        rom_req = 1'b1;
        if (rom_ack) state_nxt = ST_IDLE;
      end
      ST_DRIVE: begin
        cart_data_en = 1'b1;
        if (!sel) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_cart_responder.sv
module tb_md_cart_responder;

  logic        MCLK = 1'b0;
  logic        ext_reset = 1'b1;
  logic [22:0] cart_address = '0;
  logic [15:0] cart_data_in = '0;
  logic        cart_ce0_n = 1'b1, cart_oe_n = 1'b1, cart_lwr_n = 1'b1, cart_time_n = 1'b1;
  logic [15:0] cart_data;
  logic        cart_data_en, M3, rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_q = '0;

  logic [22:0] l_address = '0;
  logic [15:0] l_data_in = '0;
  logic        l_ce0_n = 1'b1, l_oe_n = 1'b1, l_lwr_n = 1'b1, l_time_n = 1'b1;
  logic [15:0] l_data;
  logic        l_data_en, l_M3, l_req;
  logic [19:0] l_addr;
  logic        l_ack = 1'b0;
  logic [15:0] l_q = '0;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [23:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [5:0]  mdl_bank[8];
  logic [15:0] last_data;

  always #5 MCLK = ~MCLK;

  md_cart_responder dut (
    .MCLK(MCLK), .ext_reset(ext_reset), .cart_address(cart_address),
    .cart_data_in(cart_data_in), .cart_ce0_n(cart_ce0_n), .cart_oe_n(cart_oe_n),
    .cart_lwr_n(cart_lwr_n), .cart_time_n(cart_time_n), .cart_data(cart_data),
    .cart_data_en(cart_data_en), .M3(M3), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_q(rom_q)
  );

  md_cart_responder #(.ROM_AW(20), .MAPPER_EN(0)) dut_lin (
    .MCLK(MCLK), .ext_reset(ext_reset), .cart_address(l_address),
    .cart_data_in(l_data_in), .cart_ce0_n(l_ce0_n), .cart_oe_n(l_oe_n),
    .cart_lwr_n(l_lwr_n), .cart_time_n(l_time_n), .cart_data(l_data),
    .cart_data_en(l_data_en), .M3(l_M3), .rom_req(l_req), .rom_addr(l_addr),
    .rom_ack(l_ack), .rom_q(l_q)
  );

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl_bank[i] = 6'(i);
    last_data = 16'h0000;
  endtask

  function automatic logic [23:0] model_map(input logic [22:0] a);
    return {mdl_bank[a[20:18]], a[17:0]};
  endfunction

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (rom_req !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Full read: scoreboard address on request, data on drive, then release.
  task automatic do_read(input logic [22:0] a, input int dly, input logic [15:0] q, input string nm);
    int cyc;
    logic [23:0] ea;
    logic [15:0] ed;
    exp_addr_q.push_back(model_map(a));
    exp_data_q.push_back(q);
    cart_address = a;
    cart_ce0_n = 1'b0;
    cart_oe_n = 1'b0;
    wait_req(cyc);
    ea = exp_addr_q.pop_front();
    ed = exp_data_q.pop_front();
    n_vec++;
    if (cyc !== 3) begin
      n_bad++;
      $display("FAIL %s req_latency: got %0d cycles want 3", nm, cyc);
    end
    if (rom_req === 1'b1) begin
      n_vec++;
      if (rom_addr !== ea) begin
        n_bad++;
        $display("FAIL %s rom_addr: got %h want %h", nm, rom_addr, ea);
      end
      repeat (dly) tick();
      rom_q = q;
      rom_ack = 1'b1;
      tick();
      rom_ack = 1'b0;
      rom_q = 16'h0000;
      n_vec++;
      if (cart_data_en !== 1'b1 || rom_req !== 1'b0 || cart_data !== ed) begin
        n_bad++;
        $display("FAIL %s drive: got en=%b req=%b data=%h want en=1 req=0 data=%h",
                 nm, cart_data_en, rom_req, cart_data, ed);
      end
      last_data = ed;
    end
    cart_oe_n = 1'b1;
    cart_ce0_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (cart_data_en !== 1'b1) begin
      n_bad++;
      $display("FAIL %s early_release: got en=%b want 1", nm, cart_data_en);
    end
    tick();
    n_vec++;
    if (cart_data_en !== 1'b0 || cart_data !== last_data) begin
      n_bad++;
      $display("FAIL %s release: got en=%b data=%h want en=0 data=%h",
               nm, cart_data_en, cart_data, last_data);
    end
    tick();
  endtask

  task automatic bank_write(input logic [6:0] lo, input logic [15:0] d, input logic ce0_lvl);
    cart_address = {16'h0000, lo};
    cart_data_in = d;
    cart_ce0_n = ce0_lvl;
    cart_time_n = 1'b0;
    cart_lwr_n = 1'b0;
    repeat (4) tick();
    cart_time_n = 1'b1;
    cart_lwr_n = 1'b1;
    cart_ce0_n = 1'b1;
    repeat (3) tick();
    if (ce0_lvl && lo[6:3] == 4'hF && lo[2:0] != 3'd0) mdl_bank[lo[2:0]] = d[5:0];
  endtask

  task automatic test_reset();
    ext_reset = 1'b1;
    repeat (2) tick();
    ext_reset = 1'b0;
    model_reset();
    n_vec++;
    if (rom_req !== 1'b0 || rom_addr !== 24'h0 || cart_data !== 16'h0 ||
        cart_data_en !== 1'b0 || M3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got req=%b addr=%h data=%h en=%b m3=%b want all zero",
               rom_req, rom_addr, cart_data, cart_data_en, M3);
    end
    n_vec++;
    if (l_req !== 1'b0 || l_addr !== 20'h0 || l_data_en !== 1'b0 || l_M3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_lin: got req=%b addr=%h en=%b m3=%b want all zero",
               l_req, l_addr, l_data_en, l_M3);
    end
  endtask

  task automatic test_basic_read();
    do_read(23'h000010, 3, 16'hBEEF, "basic");
    do_read(23'h000011, 0, 16'h5A5A, "ack_same_cycle");
  endtask

  task automatic test_bank_write();
    bank_write(7'h7A, 16'h0009, 1'b1);
    do_read(23'h080004, 2, 16'h1111, "bank2");
  endtask

  task automatic test_bank0();
    bank_write(7'h78, 16'h0015, 1'b1);
    do_read(23'h000000, 1, 16'h2222, "bank0_fixed");
  endtask

  task automatic test_rom_write_ignored();
    bank_write(7'h7C, 16'h0011, 1'b0);
    bank_write(7'h6D, 16'h0022, 1'b1);
    do_read(23'h100000, 1, 16'h3333, "rom_write_ignored");
    do_read(23'h140123, 1, 16'h4444, "outside_window");
  endtask

  task automatic test_abort();
    int cyc;
    bit en_seen, req_lost;
    logic [23:0] ea;
    exp_addr_q.push_back(model_map(23'h0BEEF0));
    cart_address = 23'h0BEEF0;
    cart_ce0_n = 1'b0;
    cart_oe_n = 1'b0;
    wait_req(cyc);
    ea = exp_addr_q.pop_front();
    n_vec++;
    if (rom_req !== 1'b1 || rom_addr !== ea) begin
      n_bad++;
      $display("FAIL abort_req: got req=%b addr=%h want req=1 addr=%h", rom_req, rom_addr, ea);
    end
    cart_oe_n = 1'b1;
    en_seen = 1'b0;
    req_lost = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cart_data_en !== 1'b0) en_seen = 1'b1;
      if (rom_req !== 1'b1) req_lost = 1'b1;
    end
    n_vec++;
    if (en_seen || req_lost) begin
      n_bad++;
      $display("FAIL abort_hold: got en_seen=%b req_lost=%b want 0 0", en_seen, req_lost);
    end
    rom_q = 16'hDEAD;
    rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0;
    rom_q = 16'h0000;
    cart_ce0_n = 1'b1;
    n_vec++;
    if (rom_req !== 1'b0 || cart_data_en !== 1'b0 || cart_data !== last_data) begin
      n_bad++;
      $display("FAIL abort_ack: got req=%b en=%b data=%h want req=0 en=0 data=%h",
               rom_req, cart_data_en, cart_data, last_data);
    end
    repeat (3) tick();
    n_vec++;
    if (cart_data_en !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_late_en: got %b want 0", cart_data_en);
    end
    do_read(23'h000020, 2, 16'h7777, "after_abort");
  endtask

  task automatic test_reset_mid_drive();
    int cyc;
    logic [23:0] ea;
    bank_write(7'h7B, 16'h002A, 1'b1);
    exp_addr_q.push_back(model_map(23'h0C0000));
    cart_address = 23'h0C0000;
    cart_ce0_n = 1'b0;
    cart_oe_n = 1'b0;
    wait_req(cyc);
    ea = exp_addr_q.pop_front();
    n_vec++;
    if (rom_addr !== ea) begin
      n_bad++;
      $display("FAIL bank3_addr: got %h want %h", rom_addr, ea);
    end
    rom_q = 16'hCAFE;
    rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0;
    n_vec++;
    if (cart_data_en !== 1'b1 || cart_data !== 16'hCAFE) begin
      n_bad++;
      $display("FAIL pre_reset_drive: got en=%b data=%h want en=1 data=cafe", cart_data_en, cart_data);
    end
    ext_reset = 1'b1;
    cart_ce0_n = 1'b1;
    cart_oe_n = 1'b1;
    tick();
    ext_reset = 1'b0;
    model_reset();
    n_vec++;
    if (cart_data_en !== 1'b0 || rom_req !== 1'b0 || cart_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL mid_drive_reset: got en=%b req=%b data=%h want 0 0 0000",
               cart_data_en, rom_req, cart_data);
    end
    repeat (2) tick();
    do_read(23'h0C0004, 1, 16'h8888, "bank3_after_reset");
  endtask

  task automatic test_linear();
    int cyc;
    logic [23:0] ea;
    exp_addr_q.push_back(24'h0ABCDE);
    l_address = 23'h1ABCDE;
    l_ce0_n = 1'b0;
    l_oe_n = 1'b0;
    cyc = 0;
    while (l_req !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    ea = exp_addr_q.pop_front();
    n_vec++;
    if (l_req !== 1'b1 || {4'h0, l_addr} !== ea) begin
      n_bad++;
      $display("FAIL linear_addr: got req=%b addr=%h want req=1 addr=%h", l_req, l_addr, ea[19:0]);
    end
    l_q = 16'h1234;
    l_ack = 1'b1;
    tick();
    l_ack = 1'b0;
    n_vec++;
    if (l_data_en !== 1'b1 || l_data !== 16'h1234 || l_req !== 1'b0) begin
      n_bad++;
      $display("FAIL linear_drive: got en=%b data=%h req=%b want 1 1234 0", l_data_en, l_data, l_req);
    end
    l_ce0_n = 1'b1;
    l_oe_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_read();
    test_bank_write();
    test_bank0();
    test_rom_write_ignored();
    test_abort();
    test_reset_mid_drive();
    test_linear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
